// File: rtl/cpc_ram_pkg.sv
// cpc_ram_pkg: shared types and constants for the CPC
// RAM expansion controller and its write-cycle tracker.
package cpc_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    TAIL
  } mwr_state_t;

  localparam logic [2:0] C0 = 3'd0;
  localparam logic [2:0] C1 = 3'd1;
  localparam logic [2:0] C2 = 3'd2;
  localparam logic [2:0] C3 = 3'd3;
  localparam logic [2:0] C4 = 3'd4;
  localparam logic [2:0] C5 = 3'd5;
  localparam logic [2:0] C6 = 3'd6;
  localparam logic [2:0] C7 = 3'd7;

  localparam logic       PORT_A15 = 1'b0;
  localparam logic [3:0] PORT_HI  = 4'b1111;
  localparam logic [1:0] SEL_BITS = 2'b11;

  // Returns {hit, blk}; hit=0 leaves the access to internal RAM.
  function automatic logic [2:0] map_block(
    input logic [2:0] mode,
    input logic       a15,
    input logic       a14
  );
    logic [2:0] r;
    r = 3'b000;
    unique case (mode)
      C1:      if (a15 && a14) r = 3'b111;
      C2:      r = {1'b1, a15, a14};
      C3:      if (a15 && a14) r = 3'b111;
      C4, C5,
      C6, C7:  if (!a15 && a14) r = {1'b1, mode[1:0]};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpc_ram_ctrl_xl_mwr_fsm.sv
// cpc_mwr_fsm: tracks Z80 memory-write cycles, stretching
// the write flag for a few clocks after MREQ* rises.
module cpc_mwr_fsm
  import cpc_ram_pkg::*;
#(
  parameter int WR_TAIL = 1
) (
  input  logic clk,
  input  logic reset_b,
  input  logic mreq_b,
  input  logic rfsh_b,
  input  logic m1_b,
  input  logic rd_b,
  output logic mwr,
  output logic mwr_d,
  output logic mreq_fall
);

  localparam logic [1:0] TAIL_INIT =
    2'((WR_TAIL > 0) ? (WR_TAIL - 1) : 0);

  mwr_state_t state;
  logic [1:0] cnt;
  logic       mreq_q;
  logic       qual;

  assign qual      = !mreq_b && rfsh_b && m1_b && rd_b;
  assign mreq_fall = !mreq_b && mreq_q;
  assign mwr_d     = qual && mreq_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state  <= IDLE;
      cnt    <= '0;
      mreq_q <= 1'b1;
      mwr    <= 1'b0;
    end else begin
      mreq_q <= mreq_b;
      unique case (state)
        IDLE: begin
          if (qual) begin
            state <= WR;
            mwr   <= 1'b1;
          end
        end
        WR: begin
          if (mreq_b) begin
            if (WR_TAIL == 0) begin
              state <= IDLE;
              mwr   <= 1'b0;
            end else begin
              state <= TAIL;
              cnt   <= TAIL_INIT;
            end
          end
        end
        TAIL: begin
          if (qual) begin
            state <= WR;
          end else if (cnt == 2'd0) begin
            state <= IDLE;
            mwr   <= 1'b0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          mwr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpc_ram_ctrl_xl.sv
// cpc_ram_ctrl_xl: CPC RAM expansion controller, 64K..4MB,
// with bank port decode, block mapping and 464 shadow support.
module cpc_ram_ctrl_xl
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS = 3,
  parameter int WR_TAIL   = 1,
  parameter bit SHADOW_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [7:0]           adr_hi,
  input  logic                 iorq_b,
  input  logic                 mreq_b,
  input  logic                 rfsh_b,
  input  logic                 m1_b,
  input  logic                 rd_b,
  input  logic                 wr_b,
  input  logic                 ramrd_b,
  input  logic [7:0]           data,
  input  logic [3:0]           dip,
  output logic [BANK_BITS+1:0] ramadrhi,
  output logic                 ramcs_b,
  output logic                 ramoe_b,
  output logic                 ramwe_b,
  output logic                 ramdis,
  output logic                 adr15_ovd_en,
  output logic                 rd_ovd_en,
  output logic [BANK_BITS+2:0] bank_q
);

  localparam int BB = BANK_BITS;
  localparam logic [BB-1:0] ALIAS_MASK = ~BB'(2);

  logic [BB-1:0] bank, bank_new, sbank;
  logic [2:0]    mode, hb;
  logic [5:0]    raw6, sb6;
  logic [3:0]    dip_q;
  logic [BB+2:0] pend_val;
  logic          dip_vld, dec, dec_q, pend, hi_ok;
  logic          adr15_q, a15m, mwr, mwr_d, mreq_fall;
  logic          shadow, full_shadow, overdrive;
  logic          map_hit, shadow_rd, shadow_wr, exp_hit;
  logic          unused_bits;

  assign bank = bank_q[BB+2:3];
  assign mode = bank_q[2:0];

  assign shadow      = SHADOW_EN && dip_vld && dip_q[1];
  assign full_shadow = SHADOW_EN && dip_vld && dip_q[2];
  assign overdrive   = SHADOW_EN && dip_vld && dip_q[0];

  assign sb6   = {3'b000, dip_q[3], 2'b11};
  assign sbank = sb6[BB-1:0];
  assign raw6  = {~adr_hi[2:0], data[5:3]};

  assign unused_bits = ^{raw6, sb6, adr_hi};

  assign hi_ok = (BB <= 3) || (adr_hi[6:3] == PORT_HI);
  assign dec   = !iorq_b && !wr_b && hi_ok
              && (adr_hi[7] == PORT_A15)
              && (data[7:6] == SEL_BITS);

  always_comb begin
    bank_new = raw6[BB-1:0];
    if (shadow && (bank_new == sbank))
      bank_new = bank_new & ALIAS_MASK;
  end

  // dec_q resets high so an OUT straddling reset release is ignored.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bank_q   <= '0;
      pend_val <= '0;
      pend     <= 1'b0;
      dec_q    <= 1'b1;
      dip_q    <= '0;
      dip_vld  <= 1'b0;
      adr15_q  <= 1'b0;
    end else begin
      dec_q <= dec;
      pend  <= dec && !dec_q;
      if (dec && !dec_q)
        pend_val <= {bank_new, data[2:0]};
      if (pend)
        bank_q <= pend_val;
      if (!dip_vld) begin
        dip_q   <= dip;
        dip_vld <= 1'b1;
      end
      if (mreq_fall)
        adr15_q <= adr_hi[7];
    end
  end

  cpc_mwr_fsm #(
    .WR_TAIL (WR_TAIL)
  ) u_fsm (
    .clk       (clk),
    .reset_b   (reset_b),
    .mreq_b    (mreq_b),
    .rfsh_b    (rfsh_b),
    .m1_b      (m1_b),
    .rd_b      (rd_b),
    .mwr       (mwr),
    .mwr_d     (mwr_d),
    .mreq_fall (mreq_fall)
  );

  assign a15m    = (mode == C3) ? adr15_q : adr_hi[7];
  assign hb      = map_block(mode, a15m, adr_hi[6]);
  assign map_hit = hb[2];

  assign shadow_rd = shadow && (mode == C3) && !rd_b
                  && !adr15_q && adr_hi[6];
  assign shadow_wr = shadow && !map_hit && mwr;
  assign exp_hit   = map_hit || shadow_rd;

  always_comb begin
    ramadrhi = '0;
    if (map_hit)
      ramadrhi = {bank, hb[1:0]};
    else if (shadow_rd)
      ramadrhi = {sbank, 2'b11};
    else if (shadow)
      ramadrhi = {sbank, adr_hi[7:6]};
  end

  assign ramdis  = full_shadow || exp_hit;
  assign ramcs_b = !(exp_hit || shadow_wr || full_shadow)
                || mreq_b || !rfsh_b;
  assign ramoe_b = ramrd_b;
  assign ramwe_b = wr_b;

  assign adr15_ovd_en = overdrive && (mode == C3)
                     && adr_hi[6] && rfsh_b
                     && (shadow ? (mwr || mwr_d) : !mreq_b);
  assign rd_ovd_en    = overdrive && exp_hit && mwr;

endmodule

// File: tb/tb_cpc_ram_ctrl_xl.sv
// tb_cpc_ram_ctrl_xl: directed scoreboard bench for the
// 512K (tail 2) and 4MB (no shadow) controller builds.
module tb_cpc_ram_ctrl_xl;

  logic       clk = 1'b0;
  logic       reset_b;
  logic [7:0] adr_hi, data;
  logic       iorq_b, mreq_b, rfsh_b, m1_b;
  logic       rd_b, wr_b, ramrd_b;
  logic [3:0] dip;

  logic [4:0] r3_adr;
  logic [5:0] r3_bank;
  logic       r3_cs, r3_oe, r3_we, r3_dis, r3_a15, r3_rdo;
  logic [7:0] r6_adr;
  logic [8:0] r6_bank;
  logic       r6_cs, r6_oe, r6_we, r6_dis, r6_a15, r6_rdo;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpc_ram_ctrl_xl #(
    .BANK_BITS (3),
    .WR_TAIL   (2),
    .SHADOW_EN (1'b1)
  ) u3 (
    .clk          (clk),
    .reset_b      (reset_b),
    .adr_hi       (adr_hi),
    .iorq_b       (iorq_b),
    .mreq_b       (mreq_b),
    .rfsh_b       (rfsh_b),
    .m1_b         (m1_b),
    .rd_b         (rd_b),
    .wr_b         (wr_b),
    .ramrd_b      (ramrd_b),
    .data         (data),
    .dip          (dip),
    .ramadrhi     (r3_adr),
    .ramcs_b      (r3_cs),
    .ramoe_b      (r3_oe),
    .ramwe_b      (r3_we),
    .ramdis       (r3_dis),
    .adr15_ovd_en (r3_a15),
    .rd_ovd_en    (r3_rdo),
    .bank_q       (r3_bank)
  );

  cpc_ram_ctrl_xl #(
    .BANK_BITS (6),
    .WR_TAIL   (1),
    .SHADOW_EN (1'b0)
  ) u6 (
    .clk          (clk),
    .reset_b      (reset_b),
    .adr_hi       (adr_hi),
    .iorq_b       (iorq_b),
    .mreq_b       (mreq_b),
    .rfsh_b       (rfsh_b),
    .m1_b         (m1_b),
    .rd_b         (rd_b),
    .wr_b         (wr_b),
    .ramrd_b      (ramrd_b),
    .data         (data),
    .dip          (dip),
    .ramadrhi     (r6_adr),
    .ramcs_b      (r6_cs),
    .ramoe_b      (r6_oe),
    .ramwe_b      (r6_we),
    .ramdis       (r6_dis),
    .adr15_ovd_en (r6_a15),
    .rd_ovd_en    (r6_rdo),
    .bank_q       (r6_bank)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    scb.push_back(e);
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (scb.size() == 0) begin
      errors++;
      $display("FAIL scb_empty observed %0h expected none", obs);
      return;
    end
    e = scb.pop_front();
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             e.tag, obs, e.val);
    end
  endtask

  task automatic bus_idle();
    iorq_b  = 1'b1;
    mreq_b  = 1'b1;
    rfsh_b  = 1'b1;
    m1_b    = 1'b1;
    rd_b    = 1'b1;
    wr_b    = 1'b1;
    ramrd_b = 1'b1;
  endtask

  task automatic pe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] d);
    @(negedge clk);
    bus_idle();
    dip     = d;
    reset_b = 1'b0;
    #2;
    reset_b = 1'b1;
  endtask

  task automatic out_port(input logic [7:0] a,
                          input logic [7:0] d);
    @(negedge clk);
    adr_hi = a;
    data   = d;
    iorq_b = 1'b0;
    wr_b   = 1'b0;
    repeat (2) @(negedge clk);
    iorq_b = 1'b1;
    wr_b   = 1'b1;
    #1;
  endtask

  task automatic mem_wr(input logic [7:0] a);
    @(negedge clk);
    adr_hi = a;
    mreq_b = 1'b0;
    wr_b   = 1'b0;
  endtask

  task automatic mem_end();
    @(negedge clk);
    mreq_b  = 1'b1;
    rd_b    = 1'b1;
    wr_b    = 1'b1;
    ramrd_b = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_b = 1'b0;
    dip     = 4'b0000;
    adr_hi  = 8'h00;
    data    = 8'h00;
    bus_idle();

    push("rst_bank", 32'h0);
    push("rst_cs", 32'h1);
    push("rst_dis", 32'h0);
    push("rst_a15ovd", 32'h0);
    push("rst_rdovd", 32'h0);
    push("rst_adr", 32'h0);
    #3;
    pop(32'(r3_bank));
    pop(32'(r3_cs));
    pop(32'(r3_dis));
    pop(32'(r3_a15));
    pop(32'(r3_rdo));
    pop(32'(r3_adr));
    @(negedge clk);
    reset_b = 1'b1;

    push("out7fc2_b3", 32'h02);
    push("out7fc2_b6", 32'h002);
    out_port(8'h7F, 8'hC2);
    pop(32'(r3_bank));
    pop(32'(r6_bank));

    @(negedge clk);
    adr_hi  = 8'h80;
    mreq_b  = 1'b0;
    rd_b    = 1'b0;
    ramrd_b = 1'b0;
    push("rd8000_adr", 32'h02);
    push("rd8000_cs", 32'h0);
    push("rd8000_dis", 32'h1);
    push("rd8000_oe", 32'h0);
    #2;
    pop(32'(r3_adr));
    pop(32'(r3_cs));
    pop(32'(r3_dis));
    pop(32'(r3_oe));
    rfsh_b = 1'b0;
    push("rfsh_cs", 32'h1);
    #1;
    pop(32'(r3_cs));
    rfsh_b = 1'b1;
    mem_end();

    push("out7cc4_b6", 32'h0C4);
    push("out7cc4_b3_alias", 32'h04);
    out_port(8'h7C, 8'hC4);
    pop(32'(r6_bank));
    pop(32'(r3_bank));

    @(negedge clk);
    adr_hi = 8'h40;
    mreq_b = 1'b0;
    rd_b   = 1'b0;
    push("b6_rd4000_adr", 32'h60);
    push("b6_rd4000_cs", 32'h0);
    #2;
    pop(32'(r6_adr));
    pop(32'(r6_cs));
    adr_hi = 8'h00;
    push("b6_rd0000_cs", 32'h1);
    push("b6_rd0000_dis", 32'h0);
    #1;
    pop(32'(r6_cs));
    pop(32'(r6_dis));
    mem_end();

    push("out77c1_b3", 32'h01);
    push("out77c1_b6_nodec", 32'h0C4);
    out_port(8'h77, 8'hC1);
    pop(32'(r3_bank));
    pop(32'(r6_bank));

    push("out7f82_nodec", 32'h01);
    out_port(8'h7F, 8'h82);
    pop(32'(r3_bank));

    @(negedge clk);
    adr_hi = 8'h7F;
    data   = 8'hC5;
    iorq_b = 1'b0;
    wr_b   = 1'b0;
    repeat (3) @(negedge clk);
    data = 8'hC6;
    repeat (2) @(negedge clk);
    iorq_b = 1'b1;
    wr_b   = 1'b1;
    push("iorq_held_once", 32'h05);
    #1;
    pop(32'(r3_bank));

    @(negedge clk);
    adr_hi = 8'h7F;
    data   = 8'hC7;
    iorq_b = 1'b0;
    wr_b   = 1'b0;
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    #2;
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    iorq_b = 1'b1;
    wr_b   = 1'b1;
    repeat (2) @(negedge clk);
    push("reset_mid_out", 32'h00);
    #1;
    pop(32'(r3_bank));

    do_reset(4'b0011);
    push("c3_bank", 32'h03);
    out_port(8'h7F, 8'hC3);
    pop(32'(r3_bank));

    @(negedge clk);
    adr_hi = 8'h40;
    push("c3_pre_a15ovd", 32'h0);
    #1;
    pop(32'(r3_a15));
    mreq_b = 1'b0;
    wr_b   = 1'b0;
    push("c3_wr4000_a15ovd", 32'h1);
    push("b6_noshadow_a15ovd", 32'h0);
    push("c3_wr4000_we", 32'h0);
    #2;
    pop(32'(r3_a15));
    pop(32'(r6_a15));
    pop(32'(r3_we));
    push("shadow_wr_cs", 32'h0);
    push("shadow_wr_dis", 32'h0);
    pe();
    pop(32'(r3_cs));
    pop(32'(r3_dis));
    mem_end();

    mem_wr(8'hC0);
    push("c3_wrc000_rdovd", 32'h1);
    push("c3_wrc000_adr", 32'h03);
    pe();
    pop(32'(r3_rdo));
    pop(32'(r3_adr));
    mem_end();

    push("out7fdb_alias", 32'h0B);
    push("out7fdb_b6", 32'h01B);
    out_port(8'h7F, 8'hDB);
    pop(32'(r3_bank));
    pop(32'(r6_bank));

    push("c2_bank", 32'h02);
    out_port(8'h7F, 8'hC2);
    pop(32'(r3_bank));

    mem_wr(8'h50);
    push("tail_pre", 32'h0);
    #2;
    pop(32'(r3_rdo));
    push("tail_wr1", 32'h1);
    pe();
    pop(32'(r3_rdo));
    push("tail_wr2", 32'h1);
    pe();
    pop(32'(r3_rdo));
    @(negedge clk);
    mreq_b = 1'b1;
    wr_b   = 1'b1;
    push("tail_t1", 32'h1);
    pe();
    pop(32'(r3_rdo));
    push("tail_t2", 32'h1);
    pe();
    pop(32'(r3_rdo));
    push("tail_idle", 32'h0);
    pe();
    pop(32'(r3_rdo));

    mem_wr(8'h50);
    push("b2b_wr", 32'h1);
    pe();
    pop(32'(r3_rdo));
    @(negedge clk);
    mreq_b = 1'b1;
    wr_b   = 1'b1;
    push("b2b_tail", 32'h1);
    pe();
    pop(32'(r3_rdo));
    @(negedge clk);
    mreq_b = 1'b0;
    wr_b   = 1'b0;
    push("b2b_rewr1", 32'h1);
    pe();
    pop(32'(r3_rdo));
    push("b2b_rewr2", 32'h1);
    pe();
    pop(32'(r3_rdo));
    push("b2b_rewr3", 32'h1);
    pe();
    pop(32'(r3_rdo));
    mem_end();

    dip = 4'b0000;
    push("dipfrozen_bank", 32'h03);
    out_port(8'h7F, 8'hC3);
    pop(32'(r3_bank));
    mem_wr(8'h40);
    push("dipfrozen_a15ovd", 32'h1);
    #2;
    pop(32'(r3_a15));
    mem_end();

    do_reset(4'b0000);
    push("dipoff_bank", 32'h03);
    out_port(8'h7F, 8'hC3);
    pop(32'(r3_bank));
    mem_wr(8'h40);
    push("dipoff_a15ovd", 32'h0);
    #2;
    pop(32'(r3_a15));
    mem_end();

    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scb_left observed %0d expected 0",
               scb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
